// File: rtl/p4_router_pkg.sv
// Shared types and constants for the VNP4 router egress demux.
package p4_router_pkg;

  localparam int EGR_PORT_WIDTH_DEF = 4;
  localparam int STAT_CNT_WIDTH     = 32;

  typedef logic [EGR_PORT_WIDTH_DEF-1:0] egr_port_t;

  typedef enum logic [1:0] {
    SOF,
    FWD,
    DROP
  } demux_state_t;

endpackage

// File: rtl/p4_router_axis_skid.sv
// Two-entry AXI-Stream skid buffer. The upstream ready comes straight from a
// flop, so no combinational path runs from out_tready back to in_tready.
// A beat accepted on the input shows on the output one cycle later.
module p4_router_axis_skid #(
  parameter int DATA_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_BYTES*8-1:0] in_tdata,
  input  logic [DATA_BYTES-1:0]   in_tkeep,
  input  logic                    in_tlast,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  output logic [DATA_BYTES*8-1:0] out_tdata,
  output logic [DATA_BYTES-1:0]   out_tkeep,
  output logic                    out_tlast,
  output logic                    out_tvalid,
  input  logic                    out_tready
);

  localparam int BEAT_W = DATA_BYTES*8 + DATA_BYTES + 1;

  logic [BEAT_W-1:0] in_beat;
  logic [BEAT_W-1:0] beat_p1;
  logic [BEAT_W-1:0] skd_beat;
  logic              vld_p1;
  logic              skd_vld;
  logic              in_fire;
  logic              out_free;

  assign in_beat   = {in_tdata, in_tkeep, in_tlast};
  assign in_tready = !skd_vld;
  assign in_fire   = in_tvalid && !skd_vld;
  assign out_free  = !vld_p1 || out_tready;

  assign {out_tdata, out_tkeep, out_tlast} = beat_p1;
  assign out_tvalid = vld_p1;

  // Occupancy: output slot refills from skid first, else from the input.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      skd_vld <= 1'b0;
    end else if (out_free) begin
      vld_p1  <= skd_vld || in_fire;
      skd_vld <= 1'b0;
    end else if (in_fire) begin
      skd_vld <= 1'b1;
    end
  end

  // Beat storage; contents are qualified by the valid flags, so no reset.
  always_ff @(posedge clk) begin
    if (out_free) begin
      beat_p1 <= skd_vld ? skd_beat : in_beat;
    end else if (in_fire) begin
      skd_beat <= in_beat;
    end
  end

endmodule

// File: rtl/p4_router_egress_demux.sv
// Egress demux: fans the converged VNP4 egress stream out to one AXI-Stream
// per physical port, steering by the port index in tuser on the first beat.
// Packets addressed to a non-existent port are swallowed whole.
// Optional counters are built when P4_ROUTER_EGR_DEMUX_STATS_EN is defined.
module p4_router_egress_demux
  import p4_router_pkg::*;
#(
  parameter int NUM_EGR_PORTS  = 4,
  parameter int DATA_BYTES     = 8,
  parameter int EGR_PORT_WIDTH = 4,
  parameter int USER_WIDTH     = 16
) (
  input  logic                                          clk_ifc,
  input  logic                                          sreset_ifc,
  input  logic [DATA_BYTES*8-1:0]                       egr_bus_tdata,
  input  logic [DATA_BYTES-1:0]                         egr_bus_tkeep,
  input  logic                                          egr_bus_tlast,
  input  logic [USER_WIDTH-1:0]                         egr_bus_tuser,
  input  logic                                          egr_bus_tvalid,
  output logic                                          egr_bus_tready,
  output logic [NUM_EGR_PORTS-1:0][DATA_BYTES*8-1:0]    egr_ports_tdata,
  output logic [NUM_EGR_PORTS-1:0][DATA_BYTES-1:0]      egr_ports_tkeep,
  output logic [NUM_EGR_PORTS-1:0]                      egr_ports_tlast,
  output logic [NUM_EGR_PORTS-1:0]                      egr_ports_tuser,
  output logic [NUM_EGR_PORTS-1:0]                      egr_ports_tvalid,
  input  logic [NUM_EGR_PORTS-1:0]                      egr_ports_tready,
  output logic                                          drop_invalid,
  output logic [NUM_EGR_PORTS-1:0][STAT_CNT_WIDTH-1:0]  pkt_count,
  output logic [STAT_CNT_WIDTH-1:0]                     drop_count
);

  demux_state_t              state, state_nxt;
  logic [EGR_PORT_WIDTH-1:0] hdr_port;
  logic [EGR_PORT_WIDTH-1:0] port_q, port_nxt;
  logic [EGR_PORT_WIDTH-1:0] sel;
  logic                      hdr_ok;
  logic                      fwd;
  logic                      sel_rdy;
  logic                      in_hs;
  logic                      drop_hs;
  logic [NUM_EGR_PORTS-1:0]  skid_rdy;
  logic [NUM_EGR_PORTS-1:0]  skid_vld;

  assign hdr_port = egr_bus_tuser[EGR_PORT_WIDTH-1:0];
  assign hdr_ok   = 32'(hdr_port) < NUM_EGR_PORTS;

  generate
    if (USER_WIDTH > EGR_PORT_WIDTH) begin : g_user_rest
      logic unused_tuser;
      assign unused_tuser = ^egr_bus_tuser[USER_WIDTH-1:EGR_PORT_WIDTH];
    end
  endgenerate

  // Pick the target port: decoded header in SOF, latched port mid-packet.
  always_comb begin
    sel = port_q;
    fwd = 1'b0;
    unique case (state)
      SOF: begin
        fwd = hdr_ok;
        if (hdr_ok) sel = hdr_port;
      end
      FWD:     fwd = 1'b1;
      default: fwd = 1'b0;
    endcase
  end

  // Ready of the selected skid buffer.
  always_comb begin
    sel_rdy = 1'b0;
    for (int p = 0; p < NUM_EGR_PORTS; p++) begin
      if (32'(sel) == p) sel_rdy = skid_rdy[p];
    end
  end

  // Discarded beats are always taken; forwarded ones wait on the target.
  assign egr_bus_tready = !sreset_ifc && (fwd ? sel_rdy : 1'b1);
  assign in_hs          = egr_bus_tvalid && egr_bus_tready;

  // Offer the beat only to the selected output.
  always_comb begin
    skid_vld = '0;
    for (int p = 0; p < NUM_EGR_PORTS; p++) begin
      skid_vld[p] = egr_bus_tvalid && fwd && !sreset_ifc && (32'(sel) == p);
    end
  end

  // Next-state: packet boundaries advance on accepted beats only.
  always_comb begin
    state_nxt = state;
    port_nxt  = port_q;
    drop_hs   = 1'b0;
    if (in_hs) begin
      unique case (state)
        SOF: begin
          if (hdr_ok) begin
            port_nxt = hdr_port;
            if (!egr_bus_tlast) state_nxt = FWD;
          end else begin
            drop_hs = 1'b1;
            if (!egr_bus_tlast) state_nxt = DROP;
          end
        end
        default: if (egr_bus_tlast) state_nxt = SOF;
      endcase
    end
  end

  // FSM, latched port and the drop pulse.
  always_ff @(posedge clk_ifc) begin
    if (sreset_ifc) begin
      state        <= SOF;
      port_q       <= '0;
      drop_invalid <= 1'b0;
    end else begin
      state        <= state_nxt;
      port_q       <= port_nxt;
      drop_invalid <= drop_hs;
    end
  end

  generate
    for (genvar p = 0; p < NUM_EGR_PORTS; p++) begin : g_port
      p4_router_axis_skid #(.DATA_BYTES(DATA_BYTES)) u_skid (
        .clk        (clk_ifc),
        .rst        (sreset_ifc),
        .in_tdata   (egr_bus_tdata),
        .in_tkeep   (egr_bus_tkeep),
        .in_tlast   (egr_bus_tlast),
        .in_tvalid  (skid_vld[p]),
        .in_tready  (skid_rdy[p]),
        .out_tdata  (egr_ports_tdata[p]),
        .out_tkeep  (egr_ports_tkeep[p]),
        .out_tlast  (egr_ports_tlast[p]),
        .out_tvalid (egr_ports_tvalid[p]),
        .out_tready (egr_ports_tready[p])
      );
    end
  endgenerate

  assign egr_ports_tuser = '0;

`ifdef P4_ROUTER_EGR_DEMUX_STATS_EN
  logic [NUM_EGR_PORTS-1:0][STAT_CNT_WIDTH-1:0] pkt_cnt_q;
  logic [STAT_CNT_WIDTH-1:0]                    drop_cnt_q;

  // Wrapping packet/drop counters, each stepping independently.
  always_ff @(posedge clk_ifc) begin
    if (sreset_ifc) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int p = 0; p < NUM_EGR_PORTS; p++) begin
        if (egr_ports_tvalid[p] && egr_ports_tready[p] && egr_ports_tlast[p])
          pkt_cnt_q[p] <= pkt_cnt_q[p] + 1'b1;
      end
      if (drop_hs) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign drop_count = drop_cnt_q;
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_p4_router_egress_demux.sv
// Randomized self-checking bench for p4_router_egress_demux with a per-port
// packet scoreboard.
module tb_p4_router_egress_demux;
  import p4_router_pkg::*;

  localparam int N  = 4;
  localparam int DB = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DB*8-1:0]        in_data;
  logic [DB-1:0]          in_keep;
  logic                   in_last;
  logic [15:0]            in_user;
  logic                   in_valid;
  logic                   in_ready;
  logic [N-1:0][DB*8-1:0] o_data;
  logic [N-1:0][DB-1:0]   o_keep;
  logic [N-1:0]           o_last;
  logic [N-1:0]           o_user;
  logic [N-1:0]           o_valid;
  logic [N-1:0]           o_ready;
  logic                   drop_invalid;
  logic [N-1:0][31:0]     pkt_count;
  logic [31:0]            drop_count;

  p4_router_egress_demux #(
    .NUM_EGR_PORTS(N), .DATA_BYTES(DB), .EGR_PORT_WIDTH(4), .USER_WIDTH(16)
  ) dut (
    .clk_ifc(clk), .sreset_ifc(rst),
    .egr_bus_tdata(in_data), .egr_bus_tkeep(in_keep), .egr_bus_tlast(in_last),
    .egr_bus_tuser(in_user), .egr_bus_tvalid(in_valid), .egr_bus_tready(in_ready),
    .egr_ports_tdata(o_data), .egr_ports_tkeep(o_keep), .egr_ports_tlast(o_last),
    .egr_ports_tuser(o_user), .egr_ports_tvalid(o_valid), .egr_ports_tready(o_ready),
    .drop_invalid(drop_invalid), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t       exp_q[N][$];
  logic [31:0] exp_pkt[N];
  logic [31:0] exp_drop;
  bit          exp_pulse;
  bit          in_pkt;
  bit          cur_drop;
  egr_port_t   cur_port;
  int          cyc;
  int          pulse_cnt;
  bit          chk_lat;
  bit          rand_en;
  logic [N-1:0] rdy_mask;

  int n_chk;
  int n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Output ready generator.
  initial begin
    o_ready = '1;
    forever begin
      @(posedge clk);
      #1;
      o_ready = rand_en ? 4'($urandom) : rdy_mask;
    end
  end

  // Reference model: observes handshakes on the negative edge.
  initial begin
    cyc = 0; pulse_cnt = 0; exp_pulse = 0; in_pkt = 0; cur_drop = 0;
    cur_port = '0; exp_drop = '0;
    for (int p = 0; p < N; p++) exp_pkt[p] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        for (int p = 0; p < N; p++) begin
          exp_q[p].delete();
          exp_pkt[p] = '0;
        end
        exp_drop = '0; exp_pulse = 0; in_pkt = 0; cur_drop = 0;
      end else begin
        check("drop_invalid", drop_invalid, exp_pulse);
        if (drop_invalid) pulse_cnt++;
        exp_pulse = 0;
        for (int p = 0; p < N; p++) begin
          check($sformatf("tvalid[%0d]", p), o_valid[p], exp_q[p].size() > 0);
          if (o_valid[p] && o_ready[p] && exp_q[p].size() > 0) begin
            beat_t b;
            b = exp_q[p].pop_front();
            check($sformatf("tdata[%0d]", p), o_data[p], b.data);
            check($sformatf("tkeep[%0d]", p), o_keep[p], b.keep);
            check($sformatf("tlast[%0d]", p), o_last[p], b.last);
            if (chk_lat) check("latency", cyc - b.cyc, 1);
          end
        end
        if (in_valid && in_ready) begin
          if (!in_pkt) begin
            cur_port = in_user[3:0];
            cur_drop = 32'(cur_port) >= N;
            if (cur_drop) begin
              exp_pulse = 1;
              exp_drop  = exp_drop + 1;
            end
          end
          if (!cur_drop) begin
            beat_t b;
            b.data = in_data; b.keep = in_keep; b.last = in_last; b.cyc = cyc;
            exp_q[cur_port].push_back(b);
            if (in_last) exp_pkt[cur_port] = exp_pkt[cur_port] + 1;
          end
          in_pkt = !in_last;
        end
      end
    end
  end

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic [15:0] u, output int waits);
    bit hs;
    in_data = d; in_keep = k; in_last = l; in_user = u; in_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (hs) break;
      waits++;
      if (waits > 200) begin
        check("hs_timeout", hs, 1);
        break;
      end
    end
  endtask

  task automatic send_pkt(input int port, input int len, output int waits_tot);
    int w;
    waits_tot = 0;
    for (int i = 0; i < len; i++) begin
      logic [63:0] d;
      logic [7:0]  k;
      logic [15:0] u;
      d = {32'($urandom), 32'($urandom)};
      k = (i == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
      u = (i == 0) ? {12'($urandom), 4'(port)} : 16'($urandom);
      drive_beat(d, k, i == len - 1, u, w);
      waits_tot += w;
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    rand_en  = 1'b0;
    rdy_mask = '1;
    repeat (8) @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) check($sformatf("drained[%0d]", p), exp_q[p].size(), 0);
  endtask

  task automatic check_counts();
    for (int p = 0; p < N; p++) begin
`ifdef P4_ROUTER_EGR_DEMUX_STATS_EN
      check($sformatf("pkt_count[%0d]", p), pkt_count[p], exp_pkt[p]);
`else
      check($sformatf("pkt_count[%0d]", p), pkt_count[p], 0);
`endif
    end
`ifdef P4_ROUTER_EGR_DEMUX_STATS_EN
    check("drop_count", drop_count, exp_drop);
`else
    check("drop_count", drop_count, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int w;
    int c0;
    int p0;
    n_chk = 0; n_pass = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
    in_user = '0; rand_en = 1'b0; rdy_mask = '1; chk_lat = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", o_valid, 0);
    check("rst_tready", in_ready, 0);
    check("rst_drop", drop_invalid, 0);
    check("rst_state", dut.state, SOF);
    check_counts();
    @(posedge clk);
    #1 rst = 1'b0;

    // 3-beat packet to port 2.
    chk_lat = 1'b1;
    send_pkt(2, 3, w);
    check("t1_waits", w, 0);
    drain();
    check("t1_pkt2", exp_pkt[2], 1);
    check_counts();
    check("tuser_zero", o_user, 0);

    // 4-beat packet to invalid port 7.
    p0 = pulse_cnt;
    send_pkt(7, 4, w);
    check("t2_waits", w, 0);
    drain();
    check("t2_pulses", pulse_cnt - p0, 1);
    check_counts();

    // Back-to-back single-beat packets.
    c0 = cyc;
    send_pkt(0, 1, w); send_pkt(1, 1, w); send_pkt(0, 1, w); send_pkt(3, 1, w);
    check("t3_cycles", cyc - c0, 4);
    drain();
    check_counts();
    chk_lat = 1'b0;

    // Port 1 stalled for 10 cycles mid-packet.
    fork
      send_pkt(1, 12, w);
      begin
        repeat (4) @(posedge clk);
        #2 rdy_mask = 4'b1101;
        @(posedge clk);
        #2;
        @(negedge clk);
        @(negedge clk);
        check("t4_tready_low", in_ready, 0);
        repeat (10) @(posedge clk);
        #2 rdy_mask = '1;
      end
    join
    drain();
    check_counts();

    // Reset on beat 2 of a 5-beat packet to port 0.
    drive_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 16'h0000, w);
    in_data = 64'h5555_6666_7777_8888;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_tvalid", o_valid, 0);
    check("t5_state", dut.state, SOF);
    check("t5_tready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    send_pkt(3, 3, w);
    drain();
    check_counts();

`ifdef P4_ROUTER_EGR_DEMUX_STATS_EN
    // Counter wrap.
    force dut.pkt_cnt_q[0] = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.pkt_cnt_q[0];
    exp_pkt[0] = 32'hFFFF_FFFF;
    send_pkt(0, 2, w);
    drain();
    check("t6_wrap", pkt_count[0], 0);
    check_counts();
`endif

    // Randomized traffic with random backpressure, including invalid ports.
    rand_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send_pkt($urandom_range(0, 7), $urandom_range(1, 6), w);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    drain();
    check_counts();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/p4_router_egress_demux.md
Name: p4_router_egress_demux

Overview:
Splits the single converged egress bus leaving the VNP4 pipeline into per-port AXI-Stream outputs, one per egress physical port. The egress port is taken from the tuser metadata on the first beat of each packet. Packets whose port index is invalid are dropped whole. It is the fan-out counterpart of the ingress converging arbiter and sits between the VNP4 wrapper (or queue system) and the per-width egress adapters.

Parameters:
NUM_EGR_PORTS, 4, number of output streams; must be ≥1 and ≤2**EGR_PORT_WIDTH.
DATA_BYTES, 8, tdata bytes on the input bus and on every output.
EGR_PORT_WIDTH, 4, width of the egress-port field in tuser[EGR_PORT_WIDTH-1:0].
USER_WIDTH, 16, input tuser width; must be ≥ EGR_PORT_WIDTH.

Ports:
clk_ifc  input  Clock_int  core clock; single clock domain.
sreset_ifc  input  Reset_int  reset; synchronous, active-high.
egr_bus  input  AXIS_int.Slave (DATA_BYTES, USER_WIDTH)  converged egress stream.
egr_ports[NUM_EGR_PORTS]  output  AXIS_int.Master (DATA_BYTES)  per-port streams; tdata, tkeep and tlast are forwarded, tuser is driven 0.
drop_invalid  output  1  one-cycle pulse when a packet is dropped for an invalid port.
pkt_count[NUM_EGR_PORTS]  output  32 each  forwarded-packet counters (see Optional Feature).
drop_count  output  32  dropped-packet counter (see Optional Feature).

Behaviour:
- Reset values: all egr_ports tvalid=0; egr_bus.tready=0 during reset; drop_invalid=0; all counters=0; FSM=SOF.
- FSM states:
  - SOF: waiting for the first beat of a packet.
  - FWD: mid-packet, forwarding to the latched port.
  - DROP: mid-packet, discarding.
- SOF, first-beat decode:
  - port = egr_bus.tuser[EGR_PORT_WIDTH-1:0].
  - valid if port < NUM_EGR_PORTS.
  - Valid port: port is latched. The beat is accepted when that port's skid buffer is ready. If !tlast, go to FWD.
  - Invalid port: tready=1 and the beat is discarded. drop_invalid pulses one cycle after the handshake. If !tlast, go to DROP.
- FWD: every beat goes to the latched port. tready = that skid buffer's ready. On an accepted tlast beat, go to SOF.
- DROP: tready=1 and beats are discarded. On an accepted tlast beat, go to SOF. drop_invalid pulses only once per packet.
- A single-beat packet (tlast on the first beat) stays in SOF. Back-to-back packets run with zero bubble cycles.
- tuser is ignored on every beat except the first beat.
- Each output has a 2-entry skid buffer. Its ready is registered, so there is no combinational path from output tready to egr_bus.tready.
- Latency: 1 cycle from the input handshake to output tvalid. Throughput: 1 beat per cycle per packet.
- Head-of-line: a stalled output blocks the whole input bus. There is no reordering across ports.
- Non-selected outputs never see tvalid for another port's beats.
- Reset mid-packet:
  - FSM returns to SOF and skid buffers empty.
  - A partially sent packet is truncated, with no tlast emitted.
  - Downstream blocks share this reset.

Optional Feature:
Macro P4_ROUTER_EGR_DEMUX_STATS_EN.
- Defined:
  - pkt_count[p] increments on each tlast handshake at output p.
  - drop_count increments on each invalid-port drop.
  - Counters are 32-bit and wrap from 0xFFFFFFFF to 0.
  - Simultaneous increments on different counters are independent.
- Undefined: the counters and their logic are not elaborated, and the outputs are tied to 0. drop_invalid is always present.

Decomposition:
- Package p4_router_pkg:
  - typedef egr_port_t (logic [EGR_PORT_WIDTH-1:0]).
  - enum demux_state_t {SOF, FWD, DROP}.
  - localparam STAT_CNT_WIDTH=32.
- Sub-module p4_router_axis_skid: 2-entry AXIS skid buffer with registered ready, instantiated once per output.

Test Plan:
1. 3-beat packet with tuser=2, all outputs ready → egr_ports[2] carries 3 beats with tlast on beat 3, first tvalid 1 cycle after the input handshake; other ports stay idle; pkt_count[2]=1.
2. tuser=7 with NUM_EGR_PORTS=4, 4-beat packet → all beats accepted with tready=1; no output tvalid; drop_invalid pulses exactly once; drop_count=1.
3. Back-to-back 1-beat packets to ports 0,1,0,3 with continuous tvalid → zero bubbles; order preserved per port; pkt_count={2,1,0,1}.
4. egr_ports[1].tready held low for 10 cycles mid-packet → egr_bus.tready drops within 2 cycles; no beat lost or duplicated after release; data matches the scoreboard.
5. Reset asserted on beat 2 of a 5-beat packet to port 0 → next cycle all tvalid=0 and FSM=SOF; the following packet to port 3 routes correctly.
6. With STATS_EN, preload pkt_count[0] to 0xFFFFFFFF (force), then send 1 packet to port 0 → pkt_count[0]=0.
